// File: rtl/kband_ctrl_pkg.sv
// kband_ctrl_pkg: opcodes, FSM state encoding and PIO word field positions shared with the HPS driver
package kband_ctrl_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_LOAD_A = 3'd2;
    localparam logic [2:0] OP_LOAD_B = 3'd3;
    localparam logic [2:0] OP_RUN    = 3'd4;
    localparam logic [2:0] OP_ABORT  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CMD_TOG    = 31;
    localparam int CMD_OP_LSB = 28;
    localparam int STS_CNT_W  = 26;

endpackage

// File: rtl/kband_pio_cmd_sequencer.sv
// kband_pio_cmd_sequencer: decodes toggle-framed PIO command words and sequences the KBand engine
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_word              [31] toggle, [30:28] opcode, [27:0] argument
//   status_word           [31] ack, [30:28] state, [27] error, [26] busy, [25:0] count (registered)
//   ld_valid / ld_ready   load stream handshake, ready gated by the sequencer
//   ld_sel                0 = sequence A buffer, 1 = sequence B buffer
//   eng_clr, eng_run      engine clear and run enables
//   eng_done              engine completion (level or pulse)
//   done_irq              one-cycle pulse when a command completes or is rejected
module kband_pio_cmd_sequencer
    import kband_ctrl_pkg::*;
#(
    parameter int CNT_W      = 26,
    parameter int CLR_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cmd_word,
    output logic [31:0] status_word,
    input  logic        ld_valid,
    output logic        ld_ready,
    output logic        ld_sel,
    output logic        eng_clr,
    output logic        eng_run,
    input  logic        eng_done,
    output logic        done_irq
);

    state_t           state, state_nx;
    logic [2:0]       op, cmd_op;
    logic [CNT_W-1:0] arg, count;
    logic             tog_seen, ack, error, pend;
    logic             new_cmd, busy, beat, timeout, unused_bits;

    assign cmd_op      = cmd_word[CMD_OP_LSB +: 3];
    assign new_cmd     = cmd_word[CMD_TOG] != tog_seen;
    assign busy        = state inside {ST_CLEAR, ST_LOAD, ST_RUN};
    assign beat        = ld_valid && ld_ready;
    assign timeout     = (arg != '0) && (count == arg - CNT_W'(1));
    assign unused_bits = ^cmd_word[27:CNT_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // pend marks the decode cycle spent in IDLE between detecting a toggle and entering the target state
    always_comb begin
        state_nx = state;
        if (busy && new_cmd && cmd_op == OP_ABORT) begin
            state_nx = ST_DONE;
        end else begin
            case (state)
                ST_IDLE:  if (pend) state_nx = (op == OP_CLEAR) ? ST_CLEAR :
                                               (op == OP_RUN)   ? ST_RUN   :
                                               ((op == OP_LOAD_A || op == OP_LOAD_B) && arg != '0) ? ST_LOAD : ST_DONE;
                ST_CLEAR: if (count == CNT_W'(CLR_CYCLES - 1)) state_nx = ST_DONE;
                ST_LOAD:  if (beat && count + CNT_W'(1) == arg) state_nx = ST_DONE;
                ST_RUN:   if (eng_done || timeout) state_nx = ST_DONE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // all strobes decode from registers so reset drops them immediately
    always_comb begin
        eng_clr  = state == ST_CLEAR;
        eng_run  = state == ST_RUN;
        ld_ready = (state == ST_LOAD) && (count != arg);
        done_irq = state == ST_DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= 1'b0;
            op       <= OP_NOP;
            arg      <= '0;
            count    <= '0;
            tog_seen <= 1'b0;
            ack      <= 1'b0;
            error    <= 1'b0;
            ld_sel   <= 1'b0;
        end else begin
            pend <= 1'b0;
            if (state == ST_IDLE && !pend && new_cmd) begin
                pend     <= 1'b1;
                op       <= cmd_op;
                arg      <= cmd_word[CNT_W-1:0];
                tog_seen <= cmd_word[CMD_TOG];
                count    <= '0;
                error    <= cmd_op > OP_ABORT;
                ld_sel   <= cmd_op == OP_LOAD_B;
            end else begin
                // a toggle while busy is either an abort or a rejection; both are flagged and absorbed
                if (busy && new_cmd) begin
                    tog_seen <= cmd_word[CMD_TOG];
                    error    <= 1'b1;
                end
                if (state == ST_RUN && !eng_done && timeout) error <= 1'b1;
                if ((state == ST_CLEAR || state == ST_RUN || beat) && !(&count)) count <= count + CNT_W'(1);
                if (state == ST_DONE) ack <= tog_seen;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) status_word <= '0;
        else          status_word <= {ack, state, error, busy, STS_CNT_W'(count)};
    end

endmodule

// File: tb/tb_kband_pio_cmd_sequencer.sv
// tb_kband_pio_cmd_sequencer: table-driven, hand-written and randomized checks of the command sequencer
module tb_kband_pio_cmd_sequencer;
    import kband_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cmd_word = '0;
    logic [31:0] status_word;
    logic        ld_valid = 1'b0;
    logic        ld_ready, ld_sel, eng_clr, eng_run, done_irq;
    logic        eng_done = 1'b0;

    kband_pio_cmd_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cmd_word(cmd_word), .status_word(status_word),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .eng_clr(eng_clr),
        .eng_run(eng_run), .eng_done(eng_done), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [25:0] arg;
        int          done_at;
        int          bub;
        int          e_first;
        int          e_act;
        int          e_beats;
        int          e_lat;
        logic        e_err;
        logic [25:0] e_cnt;
    } vec_t;

    vec_t tbl[14];
    int   passed = 0;
    int   total = 0;
    bit   tog = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [25:0] a);
        tog = ~tog;
        cmd_word = {tog, op, 2'b00, a};
    endtask

    function automatic logic [31:0] sts(input logic err, input logic [25:0] cnt);
        return {tog, 3'b000, err, 1'b0, cnt};
    endfunction

    // Issues a command at a falling edge and watches it until done_irq, returning what was observed.
    task automatic run_seq(input logic [2:0] op, input logic [25:0] a, input int done_at, input int bub,
                           output int first, output int act, output int beats, output int lat,
                           output bit sel_ok, output bit pulse_ok);
        int runc;
        runc = 0; first = 0; act = 0; beats = 0; lat = 0; sel_ok = 1'b1;
        issue(op, a);
        for (int c = 1; c <= 3000 && lat == 0; c++) begin
            @(negedge clk);
            if (first == 0 && (eng_clr || eng_run || ld_ready)) first = c;
            if (eng_clr || eng_run) act++;
            if (ld_ready && ld_sel != (op == OP_LOAD_B)) sel_ok = 1'b0;
            if (eng_run) runc++;
            eng_done = eng_run && runc == done_at;
            ld_valid = $urandom_range(99) >= bub;
            if (ld_valid && ld_ready) beats++;
            if (done_irq) lat = c;
        end
        ld_valid = 1'b0;
        eng_done = 1'b0;
        @(negedge clk);
        pulse_ok = !done_irq;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int first, act, beats, lat, got, a, d, exp_len;
        bit sel_ok, pulse_ok, quiet, rej, exp_err, saw_run;
        logic [2:0] op;

        tbl[0]  = '{OP_CLEAR,  26'd0,   0,  0, 2,  4, 0,  6, 1'b0, 26'd4};
        tbl[1]  = '{OP_NOP,    26'd0,   0,  0, 0,  0, 0,  2, 1'b0, 26'd0};
        tbl[2]  = '{3'd6,      26'd0,   0,  0, 0,  0, 0,  2, 1'b1, 26'd0};
        tbl[3]  = '{3'd7,      26'd9,   0,  0, 0,  0, 0,  2, 1'b1, 26'd0};
        tbl[4]  = '{OP_ABORT,  26'd0,   0,  0, 0,  0, 0,  2, 1'b0, 26'd0};
        tbl[5]  = '{OP_LOAD_A, 26'd0,   0,  0, 0,  0, 0,  2, 1'b0, 26'd0};
        tbl[6]  = '{OP_LOAD_B, 26'd5,   0,  0, 2,  0, 5,  7, 1'b0, 26'd5};
        tbl[7]  = '{OP_LOAD_A, 26'd3,   0,  0, 2,  0, 3,  5, 1'b0, 26'd3};
        tbl[8]  = '{OP_LOAD_B, 26'd5,   0, 50, 2,  0, 5, -1, 1'b0, 26'd5};
        tbl[9]  = '{OP_RUN,    26'd100, 37, 0, 2, 37, 0, 39, 1'b0, 26'd37};
        tbl[10] = '{OP_RUN,    26'd10,  0,  0, 2, 10, 0, 12, 1'b1, 26'd10};
        tbl[11] = '{OP_RUN,    26'd0,   20, 0, 2, 20, 0, 22, 1'b0, 26'd20};
        tbl[12] = '{OP_RUN,    26'd5,   5,  0, 2,  5, 0,  7, 1'b0, 26'd5};
        tbl[13] = '{OP_RUN,    26'd5,   6,  0, 2,  5, 0,  7, 1'b1, 26'd5};

        // reset behaviour and quiet idle
        repeat (3) @(negedge clk);
        check("reset_status", status_word, 32'h0);
        check("reset_outputs", {ld_ready, ld_sel, eng_clr, eng_run, done_irq}, 5'b0);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ld_ready || eng_clr || eng_run || done_irq || status_word != 0) quiet = 1'b0;
        end
        check("idle_quiet", quiet, 1'b1);

        // table-driven single commands
        foreach (tbl[i]) begin
            run_seq(tbl[i].op, tbl[i].arg, tbl[i].done_at, tbl[i].bub, first, act, beats, lat, sel_ok, pulse_ok);
            check($sformatf("v%0d_first", i), first, tbl[i].e_first);
            check($sformatf("v%0d_active", i), act, tbl[i].e_act);
            check($sformatf("v%0d_beats", i), beats, tbl[i].e_beats);
            if (tbl[i].e_lat >= 0) check($sformatf("v%0d_latency", i), lat, tbl[i].e_lat);
            else check($sformatf("v%0d_completed", i), lat != 0, 1'b1);
            check($sformatf("v%0d_irq_pulse", i), pulse_ok, 1'b1);
            if (tbl[i].op == OP_LOAD_A || tbl[i].op == OP_LOAD_B) check($sformatf("v%0d_ld_sel", i), sel_ok, 1'b1);
            check($sformatf("v%0d_status", i), status_word, sts(tbl[i].e_err, tbl[i].e_cnt));
        end

        // ABORT after 3 of 8 load beats
        issue(OP_LOAD_A, 26'd8);
        beats = 0;
        for (int c = 0; c < 40 && beats < 3; c++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            if (ld_ready) beats++;
        end
        @(negedge clk);
        ld_valid = 1'b0;
        issue(OP_ABORT, 26'd0);
        @(negedge clk);
        check("abort_ready_drop", ld_ready, 1'b0);
        check("abort_irq", done_irq, 1'b1);
        repeat (2) @(negedge clk);
        check("abort_status", status_word, sts(1'b1, 26'd3));

        // RUN while LOAD is busy is rejected, load completes, newer toggle acked
        issue(OP_LOAD_A, 26'd4);
        got = 0; rej = 1'b0; lat = 0; saw_run = 1'b0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (done_irq) lat = c;
            if (eng_run) saw_run = 1'b1;
            ld_valid = 1'b1;
            if (ld_ready) got++;
            if (got == 1 && !rej) begin
                issue(OP_RUN, 26'd3);
                rej = 1'b1;
            end
        end
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reject_beats", got, 4);
        check("reject_no_run", saw_run, 1'b0);
        check("reject_status", status_word, sts(1'b1, 26'd4));

        // randomized loads and runs against the rule-level model
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1) == 1) begin
                op = ($urandom_range(1) == 1) ? OP_LOAD_B : OP_LOAD_A;
                a = $urandom_range(12);
                run_seq(op, 26'(a), 0, 40, first, act, beats, lat, sel_ok, pulse_ok);
                check($sformatf("rnd%0d_beats", i), beats, a);
                check($sformatf("rnd%0d_ld_sel", i), sel_ok, 1'b1);
                check($sformatf("rnd%0d_status", i), status_word, sts(1'b0, 26'(a)));
            end else begin
                a = $urandom_range(30);
                d = (a == 0) ? $urandom_range(35, 1) : $urandom_range(35);
                exp_err = !(d != 0 && (a == 0 || d <= a));
                exp_len = exp_err ? a : d;
                run_seq(OP_RUN, 26'(a), d, 0, first, act, beats, lat, sel_ok, pulse_ok);
                check($sformatf("rnd%0d_run_cycles", i), act, exp_len);
                check($sformatf("rnd%0d_latency", i), lat, exp_len + 2);
                check($sformatf("rnd%0d_status", i), status_word, sts(exp_err, 26'(exp_len)));
            end
        end

        // reset in the middle of a RUN
        issue(OP_RUN, 26'd0);
        repeat (6) @(negedge clk);
        check("midrun_running", eng_run, 1'b1);
        #2;
        reset_n = 1'b0;
        cmd_word = '0;
        tog = 1'b0;
        #1;
        check("midrun_async_drop", eng_run, 1'b0);
        quiet = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_irq || eng_run) quiet = 1'b1 & 1'b0;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done_irq || eng_run || status_word != 0) quiet = 1'b0;
        end
        check("midrun_no_irq", quiet, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
